// File: rtl/traffic_generator_gmii_tx_engine.sv
// GMII transmit engine for the traffic generator. It replays one frame from an internal
// word buffer as preamble + data, with programmable inter-frame and inter-burst gaps.
module traffic_generator_gmii_tx_engine #(
    parameter int FRAME_BUF_AWIDTH = 8,
    parameter int MIN_GAP          = 12
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [31:0]                 control_reg,
    input  logic [31:0]                 interframe_gap_reg,
    input  logic [31:0]                 interburst_gap_reg,
    input  logic [31:0]                 frames_per_burst_reg,
    input  logic [63:0]                 total_frames_reg,
    input  logic [15:0]                 frame_size_reg,
    input  logic [31:0]                 frame_buf_data,
    input  logic [FRAME_BUF_AWIDTH-1:0] frame_buf_address,
    input  logic                        frame_buf_wr,
    output logic [7:0]                  gmii_txd,
    output logic                        gmii_tx_en,
    output logic                        gmii_tx_er,
    output logic                        busy,
    output logic [63:0]                 tx_frame_count
);
    localparam int              BW        = FRAME_BUF_AWIDTH + 3;
    localparam logic [BW-1:0]   BUF_BYTES = BW'(4 * (2 ** FRAME_BUF_AWIDTH));
    localparam logic [31:0]     MIN_GAP_W = 32'(MIN_GAP);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

    state_t                      state_q, state_d;
    logic                        enable_q, enable_d;
    logic [31:0]                 cnt_q, cnt_d;
    logic [BW-1:0]               byte_cnt_q, byte_cnt_d;
    logic [31:0]                 burst_cnt_q, burst_cnt_d;
    logic [63:0]                 frame_count_q, frame_count_d;
    logic [BW-1:0]               size_q, size_d;
    logic [31:0]                 burst_q, burst_d;
    logic [31:0]                 ifg_q, ifg_d;
    logic [31:0]                 ibg_q, ibg_d;
    logic [63:0]                 total_q, total_d;
    logic [7:0]                  txd_q, txd_d;
    logic                        tx_en_q, tx_en_d;
    logic [FRAME_BUF_AWIDTH-1:0] rd_addr;
    logic [31:0]                 ram_rd_data;
    logic [31:0]                 mem [2**FRAME_BUF_AWIDTH];
    logic                        unused_ctrl;

    assign unused_ctrl = ^control_reg[31:1];

    // Frame buffer: read every cycle so the word for the next byte is always waiting.
    always_ff @(posedge clk) begin
        if (frame_buf_wr) begin
            mem[frame_buf_address] <= frame_buf_data;
        end
        ram_rd_data <= mem[rd_addr];
    end

    always_comb begin
        state_d       = state_q;
        enable_d      = control_reg[0];
        cnt_d         = cnt_q;
        byte_cnt_d    = byte_cnt_q;
        burst_cnt_d   = burst_cnt_q;
        frame_count_d = frame_count_q;
        size_d        = size_q;
        burst_d       = burst_q;
        ifg_d         = ifg_q;
        ibg_d         = ibg_q;
        total_d       = total_q;
        txd_d         = 8'h00;
        tx_en_d       = 1'b0;
        rd_addr       = '0;
        case (state_q)
            IDLE: begin
                if (enable_q && (frame_size_reg != 16'd0)) begin
                    state_d       = PREAMBLE;
                    cnt_d         = 32'd0;
                    burst_cnt_d   = 32'd0;
                    frame_count_d = 64'd0;
                    size_d        = (frame_size_reg > 16'(BUF_BYTES)) ? BUF_BYTES : frame_size_reg[BW-1:0];
                    burst_d       = (frames_per_burst_reg == 32'd0) ? 32'd1 : frames_per_burst_reg;
                    ifg_d         = (interframe_gap_reg < MIN_GAP_W) ? MIN_GAP_W : interframe_gap_reg;
                    ibg_d         = (interburst_gap_reg < MIN_GAP_W) ? MIN_GAP_W : interburst_gap_reg;
                    total_d       = total_frames_reg;
                end
            end
            PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = (cnt_q == 32'd7) ? 8'hD5 : 8'h55;
                if (cnt_q == 32'd7) begin
                    state_d    = DATA;
                    byte_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DATA: begin
                tx_en_d = 1'b1;
                case (byte_cnt_q[1:0])
                    2'd0:    txd_d = ram_rd_data[31:24];
                    2'd1:    txd_d = ram_rd_data[23:16];
                    2'd2:    txd_d = ram_rd_data[15:8];
                    default: txd_d = ram_rd_data[7:0];
                endcase
                // Address of the word holding the byte sent next cycle.
                rd_addr = byte_cnt_q[BW-2:2] + FRAME_BUF_AWIDTH'(byte_cnt_q[1:0] == 2'b11);
                if (byte_cnt_q == size_q - BW'(1)) begin
                    state_d = GAP;
                    if (frame_count_q != '1) begin
                        frame_count_d = frame_count_q + 64'd1;
                    end
                    if (burst_cnt_q + 32'd1 == burst_q) begin
                        burst_cnt_d = 32'd0;
                        cnt_d       = ibg_q - 32'd1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 32'd1;
                        cnt_d       = ifg_q - 32'd1;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + BW'(1);
                end
            end
            GAP: begin
                if (cnt_q == 32'd0) begin
                    if (!enable_q || ((total_q != 64'd0) && (frame_count_q == total_q))) begin
                        state_d = IDLE;
                    end else begin
                        state_d = PREAMBLE;
                        cnt_d   = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            enable_q      <= 1'b0;
            cnt_q         <= '0;
            byte_cnt_q    <= '0;
            burst_cnt_q   <= '0;
            frame_count_q <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            ifg_q         <= '0;
            ibg_q         <= '0;
            total_q       <= '0;
            txd_q         <= 8'h00;
            tx_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            cnt_q         <= cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            frame_count_q <= frame_count_d;
            size_q        <= size_d;
            burst_q       <= burst_d;
            ifg_q         <= ifg_d;
            ibg_q         <= ibg_d;
            total_q       <= total_d;
            txd_q         <= txd_d;
            tx_en_q       <= tx_en_d;
        end
    end

    assign gmii_txd       = txd_q;
    assign gmii_tx_en     = tx_en_q;
    assign gmii_tx_er     = 1'b0;
    assign busy           = (state_q != IDLE);
    assign tx_frame_count = frame_count_q;

endmodule

// File: tb/tb_traffic_generator_gmii_tx_engine.sv
// Self-checking bench: a cycle-level stream model of the expected GMII output is built
// from the frame/gap rules and compared against the DUT on every negative clock edge.
module tb_traffic_generator_gmii_tx_engine;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] control_reg = '0;
    logic [31:0] interframe_gap_reg = '0;
    logic [31:0] interburst_gap_reg = '0;
    logic [31:0] frames_per_burst_reg = '0;
    logic [63:0] total_frames_reg = '0;
    logic [15:0] frame_size_reg = '0;
    logic [31:0] frame_buf_data = '0;
    logic [7:0]  frame_buf_address = '0;
    logic        frame_buf_wr = 1'b0;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic [63:0] tx_frame_count;

    typedef struct {
        logic        en;
        logic [7:0]  d;
        logic        busy;
        logic        cnt_chk;
        logic [63:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  obs_q[$];
    int          gaps_q[$];
    logic [31:0] ram_model [256];
    logic [7:0]  exp036 [16];
    int          g037 [6] = '{20, 20, 100, 20, 20, 100};
    int          checks = 0;
    int          errors = 0;
    int          popped = 0;

    traffic_generator_gmii_tx_engine #(.FRAME_BUF_AWIDTH(8), .MIN_GAP(12)) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .control_reg          (control_reg),
        .interframe_gap_reg   (interframe_gap_reg),
        .interburst_gap_reg   (interburst_gap_reg),
        .frames_per_burst_reg (frames_per_burst_reg),
        .total_frames_reg     (total_frames_reg),
        .frame_size_reg       (frame_size_reg),
        .frame_buf_data       (frame_buf_data),
        .frame_buf_address    (frame_buf_address),
        .frame_buf_wr         (frame_buf_wr),
        .gmii_txd             (gmii_txd),
        .gmii_tx_en           (gmii_tx_en),
        .gmii_tx_er           (gmii_tx_er),
        .busy                 (busy),
        .tx_frame_count       (tx_frame_count)
    );

    always #4 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void pushExp(input logic en, input logic [7:0] d, input logic bsy,
                                    input logic chk, input int cnt);
        exp_t e;
        e.en = en;
        e.d = d;
        e.busy = bsy;
        e.cnt_chk = chk;
        e.cnt = 64'(cnt);
        exp_q.push_back(e);
    endfunction

    // Byte k of the frame: words are sent most significant byte first.
    function automatic logic [7:0] ramByte(input int k);
        logic [31:0] w;
        w = ram_model[k / 4];
        return 8'(w >> (24 - 8 * (k % 4)));
    endfunction

    task automatic flushRam(input int nwords);
        @(posedge clk);
        #2;
        for (int i = 0; i < nwords; i++) begin
            frame_buf_wr = 1'b1;
            frame_buf_address = 8'(i);
            frame_buf_data = ram_model[i];
            @(posedge clk);
            #2;
        end
        frame_buf_wr = 1'b0;
    endtask

    task automatic waitPopped(input int target, input string name);
        int n;
        n = 0;
        while (popped < target && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (popped < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timed out, stream position %0d need %0d", name, popped, target);
        end
    endtask

    // Builds the expected per-cycle output stream for one run, starts the run, perturbs the
    // configuration mid-run, and drops enable inside the last frame (or resets mid-frame).
    task automatic applyStimulus(input int size_reg, input int burst_reg, input int ifg_reg,
                                 input int ibg_reg, input logic [63:0] total_reg, input int nframes,
                                 input int drop_off, input int abort_idx);
        int          s, b, ifg, ibg, g, base, last_start, n;
        logic [31:0] r;
        s   = (size_reg > 1024) ? 1024 : size_reg;
        b   = (burst_reg == 0) ? 1 : burst_reg;
        ifg = (ifg_reg < 12) ? 12 : ifg_reg;
        ibg = (ibg_reg < 12) ? 12 : ibg_reg;
        @(posedge clk);
        #2;
        obs_q.delete();
        gaps_q.delete();
        frame_size_reg = 16'(size_reg);
        frames_per_burst_reg = 32'(burst_reg);
        interframe_gap_reg = 32'(ifg_reg);
        interburst_gap_reg = 32'(ibg_reg);
        total_frames_reg = total_reg;
        r = $urandom();
        control_reg = {r[31:1], 1'b1};
        base = popped;
        pushExp(1'b0, 8'h00, 1'b0, 1'b0, 0);
        pushExp(1'b0, 8'h00, 1'b0, 1'b0, 0);
        pushExp(1'b0, 8'h00, 1'b1, 1'b1, 0);
        last_start = 0;
        for (int f = 1; f <= nframes; f++) begin
            if (f == nframes) last_start = exp_q.size();
            for (int i = 0; i < 7; i++) pushExp(1'b1, 8'h55, 1'b1, 1'b1, f - 1);
            pushExp(1'b1, 8'hD5, 1'b1, 1'b1, f - 1);
            for (int k = 0; k < s; k++) pushExp(1'b1, ramByte(k), 1'b1, 1'b1, (k == s - 1) ? f : f - 1);
            g = (f % b == 0) ? ibg : ifg;
            for (int j = 1; j <= g; j++) pushExp(1'b0, 8'h00, !(f == nframes && j == g), 1'b1, f);
        end
        if (abort_idx >= 0) begin
            waitPopped(base + abort_idx + 1, "abort_point");
            exp_q.delete();
            checkOutput("pre_reset_tx_en", 64'(gmii_tx_en), 64'd1);
            checkOutput("pre_reset_count", tx_frame_count, 64'd1);
            #1 resetn = 1'b0;
            #1;
            checkOutput("async_reset_tx_en", 64'(gmii_tx_en), 64'd0);
            checkOutput("async_reset_txd", 64'(gmii_txd), 64'd0);
            checkOutput("async_reset_busy", 64'(busy), 64'd0);
            checkOutput("async_reset_count", tx_frame_count, 64'd0);
            control_reg = '0;
            repeat (3) @(posedge clk);
            #2 resetn = 1'b1;
        end else begin
            waitPopped(base + 4, "scramble_point");
            r = $urandom();
            control_reg = {r[31:1], 1'b1};
            frame_size_reg = 16'($urandom());
            frames_per_burst_reg = $urandom();
            interframe_gap_reg = 32'($urandom_range(0, 40));
            interburst_gap_reg = 32'($urandom_range(0, 40));
            total_frames_reg = {32'($urandom()), 32'($urandom())};
            waitPopped(base + last_start + drop_off + 1, "drop_point");
            r = $urandom();
            control_reg = {r[31:1], 1'b0};
            n = 0;
            while (exp_q.size() > 0 && n < 50000) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL stream_drain: %0d entries left, required 0", exp_q.size());
                exp_q.delete();
            end
            checkOutput("final_count", tx_frame_count, 64'(nframes));
            checkOutput("final_busy", 64'(busy), 64'd0);
        end
    endtask

    // Per-cycle compare against the model stream, plus observation of sent bytes and idle gaps.
    initial begin : compare
        exp_t e;
        int   low_cnt;
        bit   seen_high;
        low_cnt = 0;
        seen_high = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                checkOutput("tx_en", 64'(gmii_tx_en), 64'(e.en));
                checkOutput("txd", 64'(gmii_txd), 64'(e.d));
                checkOutput("busy", 64'(busy), 64'(e.busy));
                checkOutput("tx_er", 64'(gmii_tx_er), 64'd0);
                if (e.cnt_chk) checkOutput("frame_count", tx_frame_count, e.cnt);
            end
            if (gmii_tx_en) begin
                obs_q.push_back(gmii_txd);
                if (seen_high && low_cnt > 0) gaps_q.push_back(low_cnt);
                low_cnt = 0;
                seen_high = 1'b1;
            end else if (seen_high) begin
                low_cnt++;
                if (!busy) begin
                    gaps_q.push_back(low_cnt);
                    low_cnt = 0;
                    seen_high = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin : main
        int sz, bu, ifg, ibg, tot, nw;
        #1 resetn = 1'b0;
        #2;
        checkOutput("reset_txd", 64'(gmii_txd), 64'd0);
        checkOutput("reset_tx_en", 64'(gmii_tx_en), 64'd0);
        checkOutput("reset_tx_er", 64'(gmii_tx_er), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_count", tx_frame_count, 64'd0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;

        $display("[TB] basic 8-byte frame");
        ram_model[0] = 32'h01020304;
        ram_model[1] = 32'h05060708;
        flushRam(2);
        for (int i = 0; i < 7; i++) exp036[i] = 8'h55;
        exp036[7] = 8'hD5;
        for (int i = 0; i < 8; i++) exp036[8 + i] = 8'(i + 1);
        applyStimulus(8, 1, 12, 0, 64'd1, 1, 3, -1);
        checkOutput("req036_len", 64'(obs_q.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            if (i < obs_q.size()) checkOutput("req036_byte", 64'(obs_q[i]), 64'(exp036[i]));
        checkOutput("req036_gap_n", 64'(gaps_q.size()), 64'd1);
        if (gaps_q.size() >= 1) checkOutput("req036_gap", 64'(gaps_q[0]), 64'd12);

        $display("[TB] burst gaps");
        for (int i = 0; i < 16; i++) ram_model[i] = $urandom();
        flushRam(16);
        applyStimulus(64, 3, 20, 100, 64'd6, 6, 30, -1);
        checkOutput("req037_gap_n", 64'(gaps_q.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < gaps_q.size()) checkOutput("req037_gap", 64'(gaps_q[i]), 64'(g037[i]));

        $display("[TB] minimum gap clamp");
        applyStimulus(16, 2, 3, 3, 64'd2, 2, 0, -1);
        checkOutput("req038_gap_n", 64'(gaps_q.size()), 64'd2);
        for (int i = 0; i < 2; i++)
            if (i < gaps_q.size()) checkOutput("req038_gap", 64'(gaps_q[i]), 64'd12);

        $display("[TB] oversize frame");
        for (int i = 0; i < 256; i++) ram_model[i] = $urandom();
        flushRam(256);
        applyStimulus(2000, 1, 12, 12, 64'd1, 1, 500, -1);
        checkOutput("req038_oversize_len", 64'(obs_q.size()), 64'd1032);

        $display("[TB] zero frame size");
        @(posedge clk);
        #2;
        frame_size_reg = 16'd0;
        control_reg = 32'h1;
        repeat (20) begin
            @(negedge clk);
            checkOutput("size0_busy", 64'(busy), 64'd0);
            checkOutput("size0_tx_en", 64'(gmii_tx_en), 64'd0);
        end
        control_reg = '0;

        $display("[TB] unlimited run stopped by enable");
        applyStimulus(20, 2, 12, 15, 64'd0, 6, 18, -1);
        checkOutput("req039_len", 64'(obs_q.size()), 64'd168);

        $display("[TB] reset mid-frame");
        applyStimulus(32, 1, 12, 12, 64'd3, 3, 0, 73);
        checkOutput("post_reset_busy", 64'(busy), 64'd0);
        checkOutput("post_reset_count", tx_frame_count, 64'd0);
        applyStimulus(32, 1, 12, 12, 64'd1, 1, 5, -1);
        checkOutput("req040_len", 64'(obs_q.size()), 64'd40);
        if (obs_q.size() > 0) checkOutput("req040_first", 64'(obs_q[0]), 64'h55);

        $display("[TB] randomized runs");
        for (int t = 0; t < 8; t++) begin
            sz  = $urandom_range(1, 90);
            bu  = $urandom_range(0, 4);
            ifg = $urandom_range(0, 25);
            ibg = $urandom_range(0, 30);
            tot = $urandom_range(1, 5);
            nw  = (sz + 3) / 4;
            for (int w = 0; w < nw; w++) ram_model[w] = $urandom();
            flushRam(nw);
            applyStimulus(sz, bu, ifg, ibg, 64'(tot), tot, $urandom_range(0, 7 + sz), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
